alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning response FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, meaning request/response tag width.
REQ-003 SHALL have port: clock  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: req_valid  input  1  request offered.
REQ-006 SHALL have port: req_ready  output  1  request accepted when high with req_valid.
REQ-007 SHALL have ports: req_a, req_b  input  8  operands; req_op  input  4  opcode; req_tag  input  TAG_W  tag.
REQ-008 SHALL have ports: alu_a, alu_b  output  8  and alu_sel  output  4  driving the ALU; alu_out  input  8  and alu_carry  input  1  from the ALU.
REQ-009 SHALL have ports: rsp_valid  output  1; rsp_ready  input  1; rsp_data  output  8; rsp_carry  output  1; rsp_tag  output  TAG_W; rsp_err  output  1  unsupported opcode; rsp_mismatch  output  1  self-check failure.

Function
REQ-010 SHALL use FSM states IDLE, DRIVE, SAMPLE; one operation in flight.
REQ-011 SHALL assert req_ready only in IDLE with FIFO count < DEPTH.
REQ-012 SHALL, on handshake, register req_a/req_b/req_op into alu_a/alu_b/alu_sel and req_tag internally, then go DRIVE.
REQ-013 SHALL hold alu_a/alu_b/alu_sel stable from DRIVE through SAMPLE, then retain them until the next accept.
REQ-014 SHALL go DRIVE -> SAMPLE unconditionally; in SAMPLE push {alu_carry, alu_out, tag, err} into FIFO, then return to IDLE.
REQ-015 SHALL set err=1 when req_op > 4'd3; alu_sel still driven with req_op; data/carry taken from the ALU (expected 0).
REQ-016 SHALL achieve accept-to-rsp_valid latency of 3 cycles with empty FIFO; peak throughput one op per 3 cycles.
REQ-017 SHALL present FIFO head on rsp_* with rsp_valid = FIFO non-empty; pop on rsp_valid & rsp_ready.
REQ-018 SHALL keep rsp_* stable while rsp_valid=1 and rsp_ready=0.
REQ-019 SHALL, on simultaneous push and pop, leave count unchanged and preserve order; pointers wrap modulo DEPTH.
REQ-020 SHALL never push when full (guaranteed by REQ-011; no overflow path).

Reset
REQ-021 SHALL, on reset, force FSM to IDLE, empty FIFO, discard in-flight op, drive alu_a/alu_b/alu_sel=0, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_tag=0, rsp_err=0, rsp_mismatch=0; req_ready=1 in first cycle after release.

Configuration
REQ-022 SHALL, with ALU_SEQ_SELFCHECK_EN defined, compute expected 9-bit result (ADD a+b, SUB a-b, AND, OR, else 0) at accept and store rsp_mismatch = (expected != {alu_carry, alu_out}) per entry.
REQ-023 SHALL, without ALU_SEQ_SELFCHECK_EN, tie rsp_mismatch to 0 and omit the expected-value logic and storage.

Structure
REQ-024 SHALL place opcode enum (OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3), FSM state enum and response struct in package alu_seq_pkg.
REQ-025 SHALL implement the response buffer as sub-module alu_seq_fifo (parameterised width/depth, synchronous, async reset).

Verification
REQ-026 SHALL cover: ADD a=200 b=100 tag=3 -> rsp_data=44, rsp_carry=1, rsp_tag=3, rsp_err=0, rsp_valid 3 cycles after accept.
REQ-027 SHALL cover: SUB a=5 b=10 -> rsp_data=251, rsp_carry=1; AND a=0xF0 b=0x3C -> 0x30, carry 0; responses in issue order.
REQ-028 SHALL cover: op=4'b1010 -> rsp_err=1, rsp_data=0, rsp_carry=0, rsp_mismatch=0.
REQ-029 SHALL cover: rsp_ready=0, DEPTH=4 ops issued -> req_ready low after 4th push; one pop -> one further accept; all 5 responses in order.
REQ-030 SHALL cover: reset asserted during DRIVE -> no response emitted, FIFO empty, req_ready=1 after release.
REQ-031 SHALL cover (ALU_SEQ_SELFCHECK_EN): bench forces alu_out=0x00 for ADD 1+1 -> rsp_mismatch=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states, response payload
// and the reference ALU function used by the optional ALU_SEQ_SELFCHECK_EN self-check.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic       carry;
        logic [7:0] data;
        logic       err;
    } rsp_core_t;

    localparam logic [3:0] OP_MAX_SUPPORTED = 4'd3;

    // 9-bit {carry, data} the external ALU is expected to return; SUB carry is the borrow.
    function automatic logic [8:0] alu_expected(input logic [7:0] a,
                                                input logic [7:0] b,
                                                input logic [3:0] op);
        logic [8:0] res;
        res = 9'd0;
        case (op)
            OP_ADD:  res = {1'b0, a} + {1'b0, b};
            OP_SUB:  res = {1'b0, a} - {1'b0, b};
            OP_AND:  res = {1'b0, a & b};
            OP_OR:   res = {1'b0, a | b};
            default: res = 9'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous response FIFO with asynchronous reset; DEPTH must be a power of two so
// the pointers wrap by natural overflow.
module alu_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        // Simultaneous push and pop leaves the occupancy unchanged.
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues one operation at a time to an external ALU (IDLE -> DRIVE -> SAMPLE) and queues
// tagged results. Define ALU_SEQ_SELFCHECK_EN to flag results that disagree with a reference.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    input  logic [3:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [7:0]       alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_carry,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             rsp_mismatch
);

    localparam int CORE_W = $bits(rsp_core_t);
`ifdef ALU_SEQ_SELFCHECK_EN
    localparam int FIFO_W = CORE_W + TAG_W + 1;
`else
    localparam int FIFO_W = CORE_W + TAG_W;
`endif

    seq_state_e       state_q, state_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             accept, push, pop;
    logic             fifo_empty, fifo_full;
    rsp_core_t        push_core, head_core;
    logic [TAG_W-1:0] head_tag;
    logic [FIFO_W-1:0] push_data, head;

    // Request side: valid/ready, transfer on the rising edge where both are high.
    assign req_ready = (state_q == IDLE) && !fifo_full;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        tag_d     = tag_q;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_a_d   = req_a;
                    alu_b_d   = req_b;
                    alu_sel_d = req_op;
                    tag_d     = req_tag;
                    state_d   = DRIVE;
                end
            end
            DRIVE:  state_d = SAMPLE;
            SAMPLE: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            tag_q     <= tag_d;
        end
    end

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_sel = alu_sel_q;

    always_comb begin
        push_core       = '0;
        push_core.carry = alu_carry;
        push_core.data  = alu_out;
        push_core.err   = (alu_sel_q > OP_MAX_SUPPORTED);
    end

`ifdef ALU_SEQ_SELFCHECK_EN
    logic [8:0] exp_q, exp_d;
    logic       mismatch, head_mismatch;

    // Reference captured at accept, compared while the ALU result is sampled.
    assign exp_d    = accept ? alu_expected(req_a, req_b, req_op) : exp_q;
    assign mismatch = (exp_q != {alu_carry, alu_out});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) exp_q <= '0;
        else       exp_q <= exp_d;
    end

    assign push_data = {push_core, tag_q, mismatch};
    assign {head_core, head_tag, head_mismatch} = head;
    assign rsp_mismatch = rsp_valid && head_mismatch;
`else
    assign push_data = {push_core, tag_q};
    assign {head_core, head_tag} = head;
    assign rsp_mismatch = 1'b0;
`endif

    assign pop = rsp_valid && rsp_ready;

    alu_seq_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // Response fields read as zero while the queue is empty.
    assign rsp_valid = !fifo_empty;
    assign rsp_data  = rsp_valid ? head_core.data  : '0;
    assign rsp_carry = rsp_valid ? head_core.carry : 1'b0;
    assign rsp_err   = rsp_valid ? head_core.err   : 1'b0;
    assign rsp_tag   = rsp_valid ? head_tag        : '0;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural external ALU; define
// ALU_SEQ_SELFCHECK_EN to include the forced-mismatch sequence.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clock;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_a, req_b;
    logic [3:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic [7:0]       alu_a, alu_b;
    logic [3:0]       alu_sel;
    logic [7:0]       alu_out;
    logic             alu_carry;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;
    logic             rsp_carry;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             rsp_mismatch;

    logic             force_zero;
    logic [8:0]       alu_res;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [3:0] tag;
        logic [7:0] exp_data;
        logic       exp_carry;
        logic       exp_err;
    } vec_t;

    vec_t vecs [8];
    vec_t fill [5];
    logic [12:0] exp_q [$];

    alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .req_tag      (req_tag),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_out      (alu_out),
        .alu_carry    (alu_carry),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_carry    (rsp_carry),
        .rsp_tag      (rsp_tag),
        .rsp_err      (rsp_err),
        .rsp_mismatch (rsp_mismatch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External ALU: combinational, unsupported opcodes return zero.
    always_comb begin
        alu_res = 9'd0;
        case (alu_sel)
            4'd0:    alu_res = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1:    alu_res = {1'b0, alu_a} - {1'b0, alu_b};
            4'd2:    alu_res = {1'b0, alu_a & alu_b};
            4'd3:    alu_res = {1'b0, alu_a | alu_b};
            default: alu_res = 9'd0;
        endcase
        if (force_zero) alu_res = 9'd0;
    end
    assign alu_out   = alu_res[7:0];
    assign alu_carry = alu_res[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts and ends on a falling edge; returns on the falling edge after the accept.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic [3:0] tag);
        bit accepted;
        accepted  = 1'b0;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_tag   = tag;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                accepted = 1'b1;
                @(posedge clock);
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        req_valid = 1'b0;
        if (!accepted) check("issue_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("rsp_arrived", 32'(rsp_valid), 32'd1);
    endtask

    task automatic pop_now();
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic [12:0] e;
        e = exp_q.pop_front();
        check({name, "_valid"}, 32'(rsp_valid), 32'd1);
        check({name, "_data"},  32'(rsp_data),  32'(e[7:0]));
        check({name, "_carry"}, 32'(rsp_carry), 32'(e[8]));
        check({name, "_tag"},   32'(rsp_tag),   32'(e[12:9]));
        pop_now();
    endtask

    initial begin
        int lat;
        logic [12:0] snap;

        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        req_tag    = '0;
        rsp_ready  = 1'b0;
        force_zero = 1'b0;

        vecs[0] = '{a: 8'd200,  b: 8'd100,  op: 4'd0,    tag: 4'd3,  exp_data: 8'd44,   exp_carry: 1'b1, exp_err: 1'b0};
        vecs[1] = '{a: 8'd5,    b: 8'd10,   op: 4'd1,    tag: 4'd5,  exp_data: 8'd251,  exp_carry: 1'b1, exp_err: 1'b0};
        vecs[2] = '{a: 8'hF0,   b: 8'h3C,   op: 4'd2,    tag: 4'd6,  exp_data: 8'h30,   exp_carry: 1'b0, exp_err: 1'b0};
        vecs[3] = '{a: 8'h55,   b: 8'h22,   op: 4'b1010, tag: 4'd9,  exp_data: 8'h00,   exp_carry: 1'b0, exp_err: 1'b1};
        vecs[4] = '{a: 8'h0F,   b: 8'hA0,   op: 4'd3,    tag: 4'hA,  exp_data: 8'hAF,   exp_carry: 1'b0, exp_err: 1'b0};
        vecs[5] = '{a: 8'hFF,   b: 8'h01,   op: 4'd0,    tag: 4'hF,  exp_data: 8'h00,   exp_carry: 1'b1, exp_err: 1'b0};
        vecs[6] = '{a: 8'h80,   b: 8'h80,   op: 4'd1,    tag: 4'd1,  exp_data: 8'h00,   exp_carry: 1'b0, exp_err: 1'b0};
        vecs[7] = '{a: 8'h01,   b: 8'h01,   op: 4'hF,    tag: 4'd2,  exp_data: 8'h00,   exp_carry: 1'b0, exp_err: 1'b1};

        fill[0] = '{a: 8'd10,   b: 8'd20,   op: 4'd0,    tag: 4'd1,  exp_data: 8'd30,   exp_carry: 1'b0, exp_err: 1'b0};
        fill[1] = '{a: 8'h10,   b: 8'h01,   op: 4'd1,    tag: 4'd2,  exp_data: 8'h0F,   exp_carry: 1'b0, exp_err: 1'b0};
        fill[2] = '{a: 8'h81,   b: 8'h18,   op: 4'd3,    tag: 4'd3,  exp_data: 8'h99,   exp_carry: 1'b0, exp_err: 1'b0};
        fill[3] = '{a: 8'hFF,   b: 8'h0F,   op: 4'd2,    tag: 4'd4,  exp_data: 8'h0F,   exp_carry: 1'b0, exp_err: 1'b0};
        fill[4] = '{a: 8'h80,   b: 8'h80,   op: 4'd0,    tag: 4'd5,  exp_data: 8'h00,   exp_carry: 1'b1, exp_err: 1'b0};

        // Reset values, checked before the first rising edge after release.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_req_ready",    32'(req_ready),    32'd1);
        check("rst_rsp_valid",    32'(rsp_valid),    32'd0);
        check("rst_rsp_data",     32'(rsp_data),     32'd0);
        check("rst_rsp_tag",      32'(rsp_tag),      32'd0);
        check("rst_rsp_err",      32'(rsp_err),      32'd0);
        check("rst_rsp_mismatch", 32'(rsp_mismatch), 32'd0);
        check("rst_alu_a",        32'(alu_a),        32'd0);
        check("rst_alu_sel",      32'(alu_sel),      32'd0);
        @(negedge clock);

        // Table-driven single operations with an empty queue.
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag);
            check("drive_sel",     32'(alu_sel),      32'(vecs[i].op));
            check("drive_ready",   32'(req_ready),    32'd0);
            wait_rsp(lat);
            check("latency",       32'(lat),          32'd3);
            check("vec_data",      32'(rsp_data),     32'(vecs[i].exp_data));
            check("vec_carry",     32'(rsp_carry),    32'(vecs[i].exp_carry));
            check("vec_tag",       32'(rsp_tag),      32'(vecs[i].tag));
            check("vec_err",       32'(rsp_err),      32'(vecs[i].exp_err));
            check("vec_mismatch",  32'(rsp_mismatch), 32'd0);
            pop_now();
            check("empty_after_pop", 32'(rsp_valid),  32'd0);
            check("alu_a_held",    32'(alu_a),        32'(vecs[i].a));
            check("alu_b_held",    32'(alu_b),        32'(vecs[i].b));
        end

        // Back-pressure: fill the queue, confirm stall and stability, then one pop admits one more.
        for (int i = 0; i < DEPTH; i++) begin
            issue(fill[i].a, fill[i].b, fill[i].op, fill[i].tag);
            exp_q.push_back({fill[i].tag, fill[i].exp_carry, fill[i].exp_data});
        end
        repeat (2) @(negedge clock);
        check("full_req_ready", 32'(req_ready), 32'd0);
        snap = {rsp_tag, rsp_carry, rsp_data};
        req_a     = fill[4].a;
        req_b     = fill[4].b;
        req_op    = fill[4].op;
        req_tag   = fill[4].tag;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("full_stall", 32'(req_ready), 32'd0);
        end
        check("hold_stable", 32'({rsp_tag, rsp_carry, rsp_data}), 32'(snap));
        pop_check("fill_pop0");
        check("slot_freed", 32'(req_ready), 32'd1);
        issue(fill[4].a, fill[4].b, fill[4].op, fill[4].tag);
        exp_q.push_back({fill[4].tag, fill[4].exp_carry, fill[4].exp_data});
        repeat (2) @(negedge clock);
        check("refull_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 4; i++) pop_check("fill_drain");
        check("drained", 32'(rsp_valid), 32'd0);

        // Reset while the operation is in DRIVE: it must vanish.
        issue(8'd1, 8'd2, 4'd0, 4'd7);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_alu_a",     32'(alu_a),     32'd0);
        check("mid_rst_alu_sel",   32'(alu_sel),   32'd0);
        repeat (5) @(negedge clock);
        check("mid_rst_no_rsp",    32'(rsp_valid), 32'd0);
        check("mid_rst_ready",     32'(req_ready), 32'd1);

`ifdef ALU_SEQ_SELFCHECK_EN
        // Faulty ALU result for ADD 1+1 must be flagged.
        force_zero = 1'b1;
        issue(8'd1, 8'd1, 4'd0, 4'd8);
        wait_rsp(lat);
        check("sc_mismatch", 32'(rsp_mismatch), 32'd1);
        check("sc_data",     32'(rsp_data),     32'd0);
        check("sc_tag",      32'(rsp_tag),      32'd8);
        pop_now();
        force_zero = 1'b0;
        issue(8'd1, 8'd1, 4'd0, 4'd9);
        wait_rsp(lat);
        check("sc_clean",    32'(rsp_mismatch), 32'd0);
        check("sc_data2",    32'(rsp_data),     32'd2);
        pop_now();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
